// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB request arbiter.
// Holds the FSM state encoding and the default bus widths.
package apb_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: one-hot or zero grant.
// The pointer remembers who won last, so a tie goes to the other requester.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 1 = requester 1 was granted last; reset value lets requester 0 win the first tie
    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            last_q <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two upstream request/response channels onto one APB master request port.
// Handshake: a request moves when valid and ready are both 1 at a PCLK edge; a response likewise.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    input  logic              rsp1_ready,
    output logic              STREQ,
    output logic              SWRT,
    output logic              SSEL,
    output logic [ADDR_W-1:0] SADDR,
    output logic [DATA_W-1:0] SWDATA,
    input  logic [DATA_W-1:0] SRDATA,
    input  logic              PENABLE,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output arb_state_e        dbg_state
);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant;
    logic              accept;
    logic              done;
    logic              rsp_hs;
    logic              wr_q;
    logic              idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    rr_arb2 u_rr (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     ({req1_valid, req0_valid}),
        .update  (accept),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        done       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        STREQ      = 1'b0;
        SSEL       = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_hs     = idx_q ? rsp1_ready : rsp0_ready;
        case (state_q)
            IDLE: begin
                // ready is gated by reset so nothing is accepted while PRESETn is low
                if (PRESETn && (grant != 2'b00)) begin
                    accept     = 1'b1;
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                STREQ   = 1'b1;
                SSEL    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                SSEL = 1'b1;
                done = PENABLE && PREADY;
                if (done) state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !idx_q;
                rsp1_valid = idx_q;
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_q    <= 1'b0;
            idx_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= grant[1] ? req1_write : req0_write;
            idx_q   <= grant[1];
            addr_q  <= grant[1] ? req1_addr  : req0_addr;
            wdata_q <= grant[1] ? req1_wdata : req0_wdata;
        end
    end

    // Response data is zeroed for writes so requesters never see stale bus data
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (done) begin
            rdata_q <= wr_q ? '0 : SRDATA;
            err_q   <= PSLVERR;
        end
    end

    assign SWRT       = wr_q;
    assign SADDR      = addr_q;
    assign SWDATA     = wdata_q;
    assign rsp0_rdata = rdata_q;
    assign rsp1_rdata = rdata_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus random traffic against a
// transaction-timing model, with a small APB slave/master stand-in driving the bus inputs.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]    r_valid = '0;
  logic [1:0]    r_write = '0;
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_wdata[2];
  logic [1:0]    rsp_ready = '0;
  logic          req0_ready_w, req1_ready_w;
  logic          rsp0_valid_w, rsp1_valid_w, rsp0_err_w, rsp1_err_w;
  logic [DW-1:0] rsp0_rdata_w, rsp1_rdata_w;
  logic          STREQ_w, SWRT_w, SSEL_w;
  logic [AW-1:0] SADDR_w;
  logic [DW-1:0] SWDATA_w;
  logic [DW-1:0] SRDATA = '0;
  logic          PENABLE = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0;
  arb_state_e    dbg_state_w;
  logic [1:0]    rdy, rsp_v;

  assign rdy   = {req1_ready_w, req0_ready_w};
  assign rsp_v = {rsp1_valid_w, rsp0_valid_w};

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(r_valid[0]), .req0_write(r_write[0]), .req0_addr(r_addr[0]),
    .req0_wdata(r_wdata[0]), .req0_ready(req0_ready_w),
    .req1_valid(r_valid[1]), .req1_write(r_write[1]), .req1_addr(r_addr[1]),
    .req1_wdata(r_wdata[1]), .req1_ready(req1_ready_w),
    .rsp0_valid(rsp0_valid_w), .rsp0_rdata(rsp0_rdata_w), .rsp0_err(rsp0_err_w), .rsp0_ready(rsp_ready[0]),
    .rsp1_valid(rsp1_valid_w), .rsp1_rdata(rsp1_rdata_w), .rsp1_err(rsp1_err_w), .rsp1_ready(rsp_ready[1]),
    .STREQ(STREQ_w), .SWRT(SWRT_w), .SSEL(SSEL_w), .SADDR(SADDR_w), .SWDATA(SWDATA_w),
    .SRDATA(SRDATA), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state_w)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- APB master stand-in ----------------
  int            s_ws = 0;
  logic [DW-1:0] s_rdata = '0;
  logic          s_err = 1'b0;
  bit            s_rand = 1'b0;
  bit            noise_en = 1'b0;
  bit            master_busy = 1'b0;
  int            mw;
  logic [DW-1:0] mrd;
  logic          mer;

  always begin
    @(negedge PCLK);
    if (STREQ_w === 1'b1 && PRESETn === 1'b1) begin
      master_busy = 1'b1;
      mw  = s_rand ? int'($urandom_range(0, 3)) : s_ws;
      mrd = s_rand ? DW'($urandom) : s_rdata;
      mer = s_rand ? 1'($urandom_range(0, 1)) : s_err;
      @(posedge PCLK); #1 PENABLE = 1'b0; PREADY = 1'b0;
      @(posedge PCLK); #1 PENABLE = 1'b1; PREADY = (mw == 0); SRDATA = mrd; PSLVERR = mer;
      for (int i = 0; i < mw; i++) begin
        @(posedge PCLK); #1 PREADY = (i == mw - 1);
      end
      @(posedge PCLK); #1 PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
      master_busy = 1'b0;
    end else begin
      @(posedge PCLK); #1;
      if (noise_en) begin
        PENABLE = 1'($urandom_range(0, 1));
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        SRDATA  = DW'($urandom);
      end else begin
        PENABLE = 1'b0;
        PREADY  = 1'b0;
      end
    end
  end

  bit rand_rsp = 1'b0;
  always @(posedge PCLK) begin
    if (rand_rsp) begin
      #1 rsp_ready = 2'($urandom_range(0, 3));
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // Model tracks one outstanding transaction by owner, age since accept and completion.
  int            m_owner = -1;
  int            m_age = 0;
  bit            m_done = 1'b0;
  bit            m_last = 1'b1;
  bit            m_rst_seen = 1'b1;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_err;
  logic [1:0]    e_rdy, e_rv;
  logic          e_streq, e_ssel;
  int            m_w;

  function automatic int pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  always @(negedge PCLK) begin
    e_rdy = '0; e_rv = '0; e_streq = 1'b0; e_ssel = 1'b0;
    m_w = pick(r_valid, m_last);
    if (!PRESETn && m_rst_seen) begin
      chk("rst_ready", rdy, 2'b00);
      chk("rst_streq_ssel_swrt", {STREQ_w, SSEL_w, SWRT_w}, 3'b000);
      chk("rst_rsp_valid", rsp_v, 2'b00);
      chk("rst_rsp_err", {rsp1_err_w, rsp0_err_w}, 2'b00);
      chk("rst_saddr", SADDR_w, 0);
      chk("rst_swdata", SWDATA_w, 0);
      chk("rst_rdata", {rsp1_rdata_w, rsp0_rdata_w}, 0);
    end else if (!PRESETn) begin
      chk("rst_entry_ready", rdy, 2'b00);
    end else begin
      if (m_owner < 0) begin
        if (m_w >= 0) e_rdy[m_w] = 1'b1;
      end else if (!m_done) begin
        e_streq = (m_age == 1);
        e_ssel  = 1'b1;
      end else begin
        e_rv[m_owner] = 1'b1;
      end
      chk("ready", rdy, e_rdy);
      chk("streq", STREQ_w, e_streq);
      chk("ssel", SSEL_w, e_ssel);
      chk("rsp_valid", rsp_v, e_rv);
      if (e_ssel) begin
        chk("swrt", SWRT_w, m_wr);
        chk("saddr", SADDR_w, m_addr);
        chk("swdata", SWDATA_w, m_wdata);
      end
      if (m_owner >= 0 && m_done) begin
        chk("rsp_rdata", (m_owner == 1) ? rsp1_rdata_w : rsp0_rdata_w, m_rdata);
        chk("rsp_err", (m_owner == 1) ? rsp1_err_w : rsp0_err_w, m_err);
      end
    end
    // advance model to the state after the coming edge
    if (!PRESETn) begin
      m_owner = -1; m_done = 1'b0; m_last = 1'b1;
    end else if (m_owner < 0) begin
      if (m_w >= 0) begin
        m_owner = m_w; m_age = 1; m_done = 1'b0; m_last = (m_w == 1);
        m_wr = r_write[m_w]; m_addr = r_addr[m_w]; m_wdata = r_wdata[m_w];
      end
    end else if (!m_done) begin
      if (m_age >= 2 && PENABLE && PREADY) begin
        m_done  = 1'b1;
        m_rdata = m_wr ? '0 : SRDATA;
        m_err   = PSLVERR;
      end
      m_age++;
    end else if (rsp_ready[m_owner]) begin
      m_owner = -1;
    end
    m_rst_seen = !PRESETn;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int n, output int t_acc);
    int k = 0;
    @(negedge PCLK);
    while (!rdy[n] && k < 100) begin @(negedge PCLK); k++; end
    chk("ready_timeout", k >= 100, 0);
    t_acc = cyc;
  endtask

  // Issues one request and returns at the negedge of the first response cycle.
  task automatic xfer(input int n, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output int n_streq, output int n_bad);
    int t_acc, k;
    @(posedge PCLK); #1;
    r_valid[n] = 1'b1; r_write[n] = wr; r_addr[n] = a; r_wdata[n] = d;
    wait_ready(n, t_acc);
    @(posedge PCLK); #1 r_valid[n] = 1'b0;
    n_streq = 0; n_bad = 0; k = 0;
    do begin
      @(negedge PCLK);
      if (STREQ_w) n_streq++;
      if (SSEL_w && (SADDR_w !== a || SWDATA_w !== d || SWRT_w !== wr)) n_bad++;
      k++;
    end while (!rsp_v[n] && k < 100);
    chk("rsp_timeout", k >= 100, 0);
    lat = cyc - t_acc;
  endtask

  task automatic rand_requester(input int n, input int num);
    int t;
    for (int j = 0; j < num; j++) begin
      repeat ($urandom_range(0, 3)) @(posedge PCLK);
      #1;
      r_valid[n] = 1'b1; r_write[n] = 1'($urandom_range(0, 1));
      r_addr[n] = AW'($urandom); r_wdata[n] = DW'($urandom);
      wait_ready(n, t);
      @(posedge PCLK); #1 r_valid[n] = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  int lat, ns, nbad, t_prev, k;
  logic [1:0] got;
  logic [DW-1:0] held;

  initial begin
    r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // contention from reset: strict alternation, 5-cycle accept spacing
    s_ws = 0; s_rand = 1'b0; s_rdata = 32'h0000_5A5A; s_err = 1'b0; rsp_ready = 2'b11;
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    @(posedge PCLK); #1;
    r_valid = 2'b11; r_write = 2'b00; r_addr[0] = 32'h100; r_addr[1] = 32'h200;
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      k = 0;
      @(negedge PCLK);
      while (rdy == 2'b00 && k < 50) begin @(negedge PCLK); k++; end
      chk("t2_timeout", k >= 50, 0);
      got = rdy;
      chk("t2_grant", got, exp_q.pop_front());
      if (i > 0) chk("t2_spacing", cyc - t_prev, 5);
      t_prev = cyc;
      @(posedge PCLK); #1;
      if (i == 7) r_valid = 2'b00;
      else if (got[0]) r_addr[0] = r_addr[0] + 4;
      else r_addr[1] = r_addr[1] + 4;
    end
    repeat (8) @(posedge PCLK);

    // single read, zero wait states
    s_rdata = 32'hDEAD_BEEF;
    xfer(0, 1'b0, 32'h0000_0010, 32'h0, lat, ns, nbad);
    chk("t1_latency", lat, 4);
    chk("t1_streq_cycles", ns, 1);
    chk("t1_rdata", rsp0_rdata_w, 32'hDEAD_BEEF);
    chk("t1_err", rsp0_err_w, 0);
    repeat (2) @(posedge PCLK);

    // write with three wait states
    s_ws = 3;
    xfer(0, 1'b1, 32'h0000_0020, 32'h1234_5678, lat, ns, nbad);
    chk("t3_latency", lat, 7);
    chk("t3_streq_cycles", ns, 1);
    chk("t3_payload_unstable", nbad, 0);
    chk("t3_rdata", rsp0_rdata_w, 0);
    repeat (2) @(posedge PCLK);

    // slave error with response backpressure on requester 1
    s_ws = 0; s_err = 1'b1; s_rdata = 32'hCAFE_0001; rsp_ready = 2'b01;
    xfer(1, 1'b0, 32'h0000_0030, 32'h0, lat, ns, nbad);
    chk("t4_latency", lat, 4);
    chk("t4_err", rsp1_err_w, 1);
    held = rsp1_rdata_w;
    chk("t4_rdata", held, 32'hCAFE_0001);
    s_err = 1'b0;
    @(posedge PCLK); #1;
    r_valid[0] = 1'b1; r_write[0] = 1'b0; r_addr[0] = 32'h40;
    for (int i = 1; i < 4; i++) begin
      @(negedge PCLK);
      chk("t4_hold_valid", rsp1_valid_w, 1);
      chk("t4_hold_err", rsp1_err_w, 1);
      chk("t4_hold_rdata", rsp1_rdata_w, held);
      chk("t4_no_accept", rdy, 2'b00);
    end
    @(posedge PCLK); #1 rsp_ready[1] = 1'b1;
    @(negedge PCLK);
    chk("t4_hs_no_accept", rdy, 2'b00);
    @(posedge PCLK); #1 rsp_ready = 2'b11;
    @(negedge PCLK);
    chk("t4_accept_after_hs", rdy, 2'b01);
    @(posedge PCLK); #1 r_valid[0] = 1'b0;
    repeat (8) @(posedge PCLK);

    // reset in the middle of WAIT
    s_ws = 8;
    @(posedge PCLK); #1;
    r_valid[0] = 1'b1; r_write[0] = 1'b0; r_addr[0] = 32'h50;
    wait_ready(0, t_prev);
    @(posedge PCLK); #1 r_valid[0] = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("t5_in_wait", {SSEL_w, STREQ_w}, 2'b10);
    @(posedge PCLK); #1 PRESETn = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("t5_state_idle", dbg_state_w, 64'(IDLE));
    chk("t5_ssel", SSEL_w, 0);
    nbad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (rsp_v != 2'b00) nbad++;
    end
    chk("t5_no_rsp", nbad, 0);
    k = 0;
    while (master_busy && k < 50) begin @(posedge PCLK); k++; end
    s_ws = 0;
    @(posedge PCLK); #1 r_valid = 2'b11;
    @(negedge PCLK);
    chk("t5_tie_req0", rdy, 2'b01);
    @(posedge PCLK); #1 r_valid[0] = 1'b0;
    wait_ready(1, t_prev);
    @(posedge PCLK); #1 r_valid[1] = 1'b0;
    repeat (8) @(posedge PCLK);

    // random traffic with bus noise outside WAIT
    s_rand = 1'b1; noise_en = 1'b1; rand_rsp = 1'b1;
    fork
      rand_requester(0, 15);
      rand_requester(1, 15);
    join
    k = 0;
    while ((m_owner >= 0 || master_busy) && k < 300) begin @(posedge PCLK); k++; end
    chk("drain_timeout", k >= 300, 0);
    rand_rsp = 1'b0; noise_en = 1'b0;
    #1 rsp_ready = 2'b11;
    repeat (5) @(posedge PCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 Clock and reset SHALL be: PCLK  in  1  single block clock; PRESETn  in  1  reset, synchronous and active-low.
REQ-003 For n in {0,1}, upstream request ports SHALL be: reqn_valid  in  1  request pending; reqn_write  in  1  1=write, 0=read; reqn_addr  in  ADDR_W  target address; reqn_wdata  in  DATA_W  write data; reqn_ready  out  1  request accepted this cycle.
REQ-004 For n in {0,1}, upstream response ports SHALL be: rspn_valid  out  1  response available; rspn_rdata  out  DATA_W  read data, zero for writes; rspn_err  out  1  copy of PSLVERR; rspn_ready  in  1  response consumed.
REQ-005 Master-side outputs SHALL be: STREQ  out  1  transfer request to APB master; SWRT  out  1  write flag; SSEL  out  1  slave select; SADDR  out  ADDR_W  address; SWDATA  out  DATA_W  write data.
REQ-006 Master-side inputs SHALL be: SRDATA  in  DATA_W  read data; PENABLE  in  1  bus access phase; PREADY  in  1  slave ready; PSLVERR  in  1  slave error.

Function
REQ-007 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE: if any reqn_valid, the block SHALL grant one requester, pulse its reqn_ready for one cycle, latch write/addr/wdata and the grant index, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-009 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that requester wins.
REQ-010 ISSUE: STREQ SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-011 WAIT: STREQ SHALL be 0; a transfer completes on a cycle with PENABLE=1 and PREADY=1.
REQ-012 On completion the block SHALL capture SRDATA (zeroed for writes) and PSLVERR, then go to RESP.
REQ-013 WAIT SHALL persist indefinitely while PREADY=0; there is no timeout.
REQ-014 SSEL SHALL be 1 in ISSUE and WAIT and 0 otherwise.
REQ-015 SWRT, SADDR and SWDATA SHALL present the latched values, constant from ISSUE through WAIT.
REQ-016 RESP: rspn_valid SHALL be 1 only for the granted requester; rspn_rdata and rspn_err SHALL be held stable until rspn_ready=1; the FSM SHALL return to IDLE on the cycle after that handshake.
REQ-017 Requests SHALL NOT be accepted outside IDLE; reqn_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-018 Latency SHALL be: accept at cycle T, STREQ at T+1, APB Setup at T+2, Access at T+3; with zero wait states, rspn_valid at T+4; each wait state adds one cycle.
REQ-019 Minimum spacing between two accepts SHALL be 5 cycles (accept, ISSUE, WAIT, RESP, IDLE), with zero wait states and rspn_ready tied to 1.
REQ-020 The requester SHALL hold reqn_valid and its payload until reqn_ready; the block samples the payload only on the accept cycle.
REQ-021 Completion SHALL be sampled only in WAIT; PREADY or PENABLE activity in any other state SHALL be ignored.

Reset
REQ-022 With PRESETn=0 at a PCLK edge, state SHALL become IDLE and the last-grant pointer SHALL become 1, so requester 0 wins the first tie.
REQ-023 Under reset, STREQ, SSEL, SWRT, all reqn_ready, rspn_valid and rspn_err SHALL be 0, and SADDR, SWDATA and rspn_rdata SHALL be zero.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer with no response issued; the APB master is reset by the same PRESETn.

Structure
REQ-025 A shared package apb_arb_pkg SHALL hold the state enumeration (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and the default ADDR_W/DATA_W constants.
REQ-026 The two-way round-robin grant logic SHALL be one sub-module, rr_arb2: inputs req[1:0] and a pointer update enable; output grant[1:0], one-hot or zero.
REQ-027 Only the FSM, payload latch and response registers SHALL reside in apb_req_arbiter; the expected implementation is about 150-250 lines.

Verification
REQ-028 Single read: req0 read addr 0x0000_0010, slave returns 0xDEAD_BEEF with PREADY=1 -> STREQ high 1 cycle, rsp0_valid at T+4, rsp0_rdata=0xDEAD_BEEF, rsp0_err=0.
REQ-029 Contention: req0 and req1 valid together from reset -> req0 granted first, req1 granted next; alternating order holds over 8 transfers.
REQ-030 Wait states: write addr 0x20 data 0x1234_5678, PREADY low 3 Access cycles -> SADDR/SWDATA stable throughout, STREQ=0 in WAIT, rsp valid at T+7, rdata=0.
REQ-031 Error and backpressure: PSLVERR=1 on completion, rsp1_ready held low 4 cycles -> rsp1_valid, rsp1_err=1 stable for 4 cycles, no new accept until after the handshake.
REQ-032 Reset mid-WAIT: PRESETn=0 for 1 cycle during WAIT -> next cycle IDLE, no rspn_valid, and next request is accepted normally with req0 winning a tie.
